// File: rtl/onehot_select_seq.sv
// Registered one-hot channel decoder with valid/ready load handshake,
// out-of-range flagging and an auto-scan sequencer with programmable dwell.
module onehot_select_seq #(
  parameter int unsigned IN_W    = 4,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_idx,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   out,
  output logic               out_valid,
  output logic               err_oor,
  output logic [IN_W-1:0]    cur_idx,
  output logic               scan_wrap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam logic [IN_W-1:0] LAST_IDX = IN_W'(OUT_W - 1);

  state_t             state, state_nxt;
  logic [OUT_W-1:0]   out_nxt;
  logic               out_valid_nxt;
  logic               err_oor_nxt;
  logic [IN_W-1:0]    cur_idx_nxt;
  logic               scan_wrap_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic               in_range;
  logic [IN_W-1:0]    scan_next_idx;

  function automatic logic [OUT_W-1:0] decode(input logic [IN_W-1:0] idx);
    logic [OUT_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      if (IN_W'(i) == idx) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign in_ready      = !mode && (state != SCAN);
  assign in_range      = 32'(in_idx) < OUT_W;
  assign scan_next_idx = (cur_idx == LAST_IDX) ? '0 : cur_idx + IN_W'(1);

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out       <= '0;
      out_valid <= 1'b0;
      err_oor   <= 1'b0;
      cur_idx   <= '0;
      scan_wrap <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      out       <= out_nxt;
      out_valid <= out_valid_nxt;
      err_oor   <= err_oor_nxt;
      cur_idx   <= cur_idx_nxt;
      scan_wrap <= scan_wrap_nxt;
      cnt       <= cnt_nxt;
    end
  end

  // Next-state: clear, then scan entry/exit/advance, then load
  always_comb begin
    state_nxt     = state;
    out_nxt       = out;
    out_valid_nxt = out_valid;
    err_oor_nxt   = err_oor;
    cur_idx_nxt   = cur_idx;
    scan_wrap_nxt = 1'b0;
    cnt_nxt       = cnt;

    if (clear) begin
      state_nxt     = IDLE;
      out_nxt       = '0;
      out_valid_nxt = 1'b0;
      err_oor_nxt   = 1'b0;
      cur_idx_nxt   = '0;
      cnt_nxt       = '0;
    end else if (state != SCAN && mode) begin
      state_nxt     = SCAN;
      cur_idx_nxt   = '0;
      out_nxt       = decode('0);
      out_valid_nxt = 1'b1;
      err_oor_nxt   = 1'b0;
      cnt_nxt       = dwell;
    end else if (state == SCAN && !mode) begin
      state_nxt = HOLD;
      cnt_nxt   = '0;
    end else if (state == SCAN) begin
      if (cnt != '0) begin
        cnt_nxt = cnt - DWELL_W'(1);
      end else begin
        cur_idx_nxt   = scan_next_idx;
        out_nxt       = decode(scan_next_idx);
        out_valid_nxt = 1'b1;
        scan_wrap_nxt = (cur_idx == LAST_IDX);
        cnt_nxt       = dwell;
      end
    end else if (in_valid && in_ready) begin
      if (in_range) begin
        state_nxt     = HOLD;
        out_nxt       = decode(in_idx);
        out_valid_nxt = 1'b1;
        err_oor_nxt   = 1'b0;
        cur_idx_nxt   = in_idx;
      end else begin
        state_nxt     = IDLE;
        out_nxt       = '0;
        out_valid_nxt = 1'b0;
        err_oor_nxt   = 1'b1;
      end
    end
  end

endmodule
